pcs_40g_tx_sched: RTL and testbench

Transmit-side sequencing controller for the 40GBASE-R PCS transmit datapath (4 lanes × 64-bit blocks).
- Decides each cycle whether the datapath carries a MAC block, inserts an alignment marker on all lanes, or stalls for the 66b→64b gearbox slip.
- Drives the MAC-facing `ready_o` and the datapath's insertion and BIP-clear strobes.
- Sits between the MAC interface and the per-lane encode/scramble/marker/gearbox pipeline.

---
 rtl/pcs_40g_tx_sched.sv | 91 +++++++++
 tb/tb_pcs_40g_tx_sched.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pcs_40g_tx_sched.sv
// pcs_40g_tx_sched: per-cycle sequencing for the 40GBASE-R PCS transmit path.
// Each enabled cycle is a gearbox stall, an alignment-marker slot, or a MAC data
// slot. Outputs decode from registered state only.
// Build macro: PCS_TX_SCHED_GB_EN enables the 66b->64b gearbox stall logic;
// leave it undefined for a 66-bit PMA build, which has no stall cycles.
module pcs_40g_tx_sched #(
    parameter int LANE_N    = 4,
    parameter int AM_GAP    = 16383,
    parameter int GB_PERIOD = 33
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic                         en_i,
    output logic                         ready_o,
    output logic                         am_v_o,
    output logic                         bip_clr_o,
    output logic                         gb_stall_o,
    output logic [$clog2(GB_PERIOD)-1:0] gb_seq_o
);

    localparam int GB_W  = $clog2(GB_PERIOD);
    localparam int CNT_W = $clog2(AM_GAP + 1);
    localparam logic [CNT_W-1:0] CNT_AM   = CNT_W'(AM_GAP);
    // All lanes run in lockstep; a build with no lanes never enables.
    localparam bit               LANES_OK = (LANE_N > 0);

    logic             en_q;
    logic [CNT_W-1:0] blk_cnt_q;
    logic             bip_q;
    logic             gb_stall;
    logic             am_v;
    logic             ready;

`ifdef PCS_TX_SCHED_GB_EN
    localparam logic [GB_W-1:0] GB_LAST = GB_W'(GB_PERIOD - 1);

    logic [GB_W-1:0] gb_seq_q;

    // Gearbox phase: advances every enabled cycle, wraps at the period end.
    always_ff @(posedge clk) begin
        if (nreset)
            gb_seq_q <= '0;
        else if (en_q)
            gb_seq_q <= (gb_seq_q == GB_LAST) ? '0 : gb_seq_q + GB_W'(1);
    end

    assign gb_stall = en_q & (gb_seq_q == GB_LAST);
    assign gb_seq_o = gb_seq_q;
`else
    assign gb_stall = 1'b0;
    assign gb_seq_o = '0;
`endif

    // Stall beats marker; a marker that is due waits out the stall.
    assign am_v  = en_q & ~gb_stall & (blk_cnt_q == CNT_AM);
    assign ready = en_q & ~gb_stall & ~am_v;

    // Registered enable, so no input reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (nreset)
            en_q <= 1'b0;
        else
            en_q <= en_i & LANES_OK;
    end

    // Data-slot counter; resets to AM_GAP so the first slot after enable is a marker.
    always_ff @(posedge clk) begin
        if (nreset)
            blk_cnt_q <= CNT_AM;
        else if (en_q) begin
            if (am_v)
                blk_cnt_q <= '0;
            else if (ready)
                blk_cnt_q <= blk_cnt_q + CNT_W'(1);
        end
    end

    // BIP restart follows each marker by one cycle.
    always_ff @(posedge clk) begin
        if (nreset)
            bip_q <= 1'b0;
        else
            bip_q <= am_v;
    end

    assign ready_o    = ready;
    assign am_v_o     = am_v;
    assign gb_stall_o = gb_stall;
    assign bip_clr_o  = en_q & bip_q;

endmodule

// File: tb/tb_pcs_40g_tx_sched.sv
// Bench for pcs_40g_tx_sched with AM_GAP=7, GB_PERIOD=33. A slot-level model
// pushes predicted outputs to a scoreboard each step; a vector table covers the
// start-up sequence and hand-written sequences cover the multi-cycle corners.
module tb_pcs_40g_tx_sched;

    localparam int AM_GAP    = 7;
    localparam int GB_PERIOD = 33;
    localparam int LANE_N    = 4;
    localparam int GB_W      = $clog2(GB_PERIOD);
`ifdef PCS_TX_SCHED_GB_EN
    localparam bit GB_ON = 1'b1;
`else
    localparam bit GB_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            nreset = 1'b1;
    logic            en_i = 1'b0;
    logic            ready_o, am_v_o, bip_clr_o, gb_stall_o;
    logic [GB_W-1:0] gb_seq_o;

    always #5 clk = ~clk;

    pcs_40g_tx_sched #(.LANE_N(LANE_N), .AM_GAP(AM_GAP), .GB_PERIOD(GB_PERIOD)) dut (
        .clk(clk), .nreset(nreset), .en_i(en_i),
        .ready_o(ready_o), .am_v_o(am_v_o), .bip_clr_o(bip_clr_o),
        .gb_stall_o(gb_stall_o), .gb_seq_o(gb_seq_o)
    );

    typedef struct packed {
        logic            ready;
        logic            am;
        logic            bip;
        logic            stall;
        logic [GB_W-1:0] seq;
    } outs_t;

    typedef struct {
        logic  rst;
        logic  en;
        outs_t exp;
    } vec_t;

    outs_t sb_q[$];
    int    n_chk = 0;
    int    n_fail = 0;

    // Model: enabled-cycle phase, data slots still owed before the next marker.
    int m_en = 0, m_phase = 0, m_left = 0, m_bip = 0;
    int rdy = 0;

    function automatic outs_t model_out();
        outs_t o;
        o.stall = (m_en != 0) && GB_ON && (m_phase == GB_PERIOD - 1);
        o.am    = (m_en != 0) && !o.stall && (m_left == 0);
        o.ready = (m_en != 0) && !o.stall && !o.am;
        o.bip   = (m_en != 0) && (m_bip != 0);
        o.seq   = GB_ON ? GB_W'(m_phase) : '0;
        return o;
    endfunction

    task automatic model_edge(input logic rst, input logic en);
        outs_t o;
        o = model_out();
        if (rst) begin
            m_en = 0; m_phase = 0; m_left = 0; m_bip = 0;
        end else begin
            if (m_en != 0) begin
                m_phase = (m_phase + 1) % GB_PERIOD;
                if (o.am) m_left = AM_GAP;
                else if (o.ready) m_left = m_left - 1;
            end
            m_bip = o.am ? 1 : 0;
            m_en  = en ? 1 : 0;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle, predict, then sample #1 after the edge and score.
    task automatic step(input logic rst, input logic en, output outs_t got);
        outs_t exp;
        nreset = rst;
        en_i   = en;
        model_edge(rst, en);
        sb_q.push_back(model_out());
        @(posedge clk);
        #1;
        got.ready = ready_o;
        got.am    = am_v_o;
        got.bip   = bip_clr_o;
        got.stall = gb_stall_o;
        got.seq   = gb_seq_o;
        if (sb_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL scoreboard: queue empty");
        end else begin
            exp = sb_q.pop_front();
            chk("scoreboard", int'(got), int'(exp));
        end
        chk("onehot", ($countones({got.ready, got.am, got.stall}) <= 1) ? 1 : 0, 1);
        if (got.am) rdy = 0;
        else if (got.ready) rdy++;
    endtask

    function automatic outs_t mk(input logic r, input logic a, input logic b, input int s);
        outs_t o;
        o.ready = r; o.am = a; o.bip = b; o.stall = 1'b0;
        o.seq = GB_ON ? GB_W'(s) : '0;
        return o;
    endfunction

    initial begin
        vec_t  tbl[11];
        outs_t got;
        int    seen;
        int    rem;
        int    cnt;
        int    found;
        logic [GB_W-1:0] frz;

        // Start-up vectors: reset, then en_i=1 sampled at edge 0.
        tbl[0] = '{1'b1, 1'b0, mk(0, 0, 0, 0)};
        tbl[1] = '{1'b0, 1'b1, mk(0, 1, 0, 0)};
        tbl[2] = '{1'b0, 1'b1, mk(1, 0, 1, 1)};
        for (int k = 3; k <= 8; k++) tbl[k] = '{1'b0, 1'b1, mk(1, 0, 0, k - 1)};
        tbl[9]  = '{1'b0, 1'b1, mk(0, 1, 0, 8)};
        tbl[10] = '{1'b0, 1'b1, mk(1, 0, 1, 9)};
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rst, tbl[i].en, got);
            chk($sformatf("vec%0d", i), int'(got), int'(tbl[i].exp));
        end

        // Long enabled run from reset: stall placement, marker spacing, collision.
        step(1'b1, 1'b0, got);
        seen = 0;
        for (int c = 1; c <= 200; c++) begin
            step(1'b0, 1'b1, got);
            if (got.am) begin
                if (seen != 0) chk("am_gap", cnt, AM_GAP);
                seen = 1;
                cnt = 0;
            end else if (got.ready) cnt++;
`ifdef PCS_TX_SCHED_GB_EN
            chk("stall_slot", int'(got.stall), (c % GB_PERIOD == 0) ? 1 : 0);
            if (c == 33) chk("coll_stall", int'({got.stall, got.am}), 2);
            if (c == 34) chk("coll_am", int'({got.am, got.seq}), 1 << GB_W);
            if (c == 35) chk("coll_bip", int'(got.bip), 1);
`else
            chk("stall_off", int'(got.stall), 0);
            if (c <= 100) chk("am_every8", int'(got.am), (c % 8 == 1) ? 1 : 0);
`endif
        end

        // Find a data slot mid-gap, then drop en_i for 10 cycles.
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            step(1'b0, 1'b1, got);
            if (got.ready && rdy >= 2 && rdy <= 5) found = 1;
        end
        chk("midgap_found", found, 1);
        rem = AM_GAP - rdy;
        frz = '0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, got);
            chk("drop_quiet", int'({got.ready, got.am, got.bip, got.stall}), 0);
            if (i == 0) frz = got.seq;
            else chk("drop_seq_frozen", int'(got.seq), int'(frz));
        end
        found = 0;
        cnt = 0;
        for (int i = 0; i < 60 && found == 0; i++) begin
            step(1'b0, 1'b1, got);
            if (got.am) found = 1;
            else if (got.ready) cnt++;
        end
        chk("resume_marker_seen", found, 1);
        chk("resume_remainder", cnt, rem);

        // One-cycle reset mid-operation, then the first slot must be a marker.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, got);
        step(1'b1, 1'b1, got);
        chk("rst_quiet", int'(got), 0);
        step(1'b0, 1'b1, got);
        chk("rst_first_am", int'({got.am, got.ready}), 2);
        step(1'b0, 1'b1, got);
        chk("rst_bip", int'({got.bip, got.ready}), 3);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, got);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
